// File: rtl/mul_red_pkg.sv
// Shared constants and reduction helpers for the Kyber/Dilithium multiply-reduce array.
package mul_red_pkg;

  localparam int unsigned KQ = 3329;
  localparam int unsigned DQ = 8380417;

  // Barrett constants: KM = floor(2^24/KQ), DM = floor(2^46/DQ); both leave r < 2q.
  localparam int unsigned KM  = 5039;
  localparam int unsigned KSH = 24;
  localparam int unsigned DM  = 8396807;
  localparam int unsigned DSH = 46;

  localparam logic MODE_K = 1'b0;
  localparam logic MODE_D = 1'b1;

  localparam int MR_LAT = 4;

  function automatic logic [12:0] barrett_k(input logic [23:0] x);
    logic [36:0] t;
    logic [12:0] qe;
    t  = 37'(x) * 37'(KM);
    qe = 13'(t >> KSH);
    return 13'(37'(x) - 37'(qe) * 37'(KQ));
  endfunction

  function automatic logic [23:0] barrett_d(input logic [45:0] x);
    logic [69:0] t;
    logic [23:0] qe;
    t  = 70'(x) * 70'(DM);
    qe = 24'(t >> DSH);
    return 24'(48'(x) - 48'(qe) * 48'(DQ));
  endfunction

  function automatic logic [11:0] csub_k(input logic [12:0] r);
    return (r >= 13'(KQ)) ? 12'(r - 13'(KQ)) : 12'(r);
  endfunction

  function automatic logic [22:0] csub_d(input logic [23:0] r);
    return (r >= 24'(DQ)) ? 23'(r - 24'(DQ)) : 23'(r);
  endfunction

endpackage

// File: rtl/mul_red_lane.sv
// One 24-bit lane: operand, product, Barrett partial and corrected-result registers.
module mul_red_lane
  import mul_red_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  en,
  input  logic [2:0]  mode,
  input  logic [23:0] a,
  input  logic [23:0] w,
  output logic [23:0] res
);

  logic [23:0] a_q;
  logic [23:0] w_q;
  logic [47:0] prod_q;
  logic [25:0] red_q;
  logic [47:0] prod_d;
  logic [25:0] red_d;
  logic [23:0] res_d;

  // mode[0..2] is the mode of the beat currently held in S1..S3
  always_comb begin
    prod_d = '0;
    if (mode[0] == MODE_D)
      prod_d = {2'b00, 46'(a_q[22:0]) * 46'(w_q[22:0])};
    else
      prod_d = {24'(a_q[23:12]) * 24'(w_q[23:12]), 24'(a_q[11:0]) * 24'(w_q[11:0])};
  end

  always_comb begin
    red_d = '0;
    if (mode[1] == MODE_D)
      red_d = {2'b00, barrett_d(prod_q[45:0])};
    else
      red_d = {barrett_k(prod_q[47:24]), barrett_k(prod_q[23:0])};
  end

  always_comb begin
    res_d = '0;
    if (mode[2] == MODE_D)
      res_d = {1'b0, csub_d(red_q[23:0])};
    else
      res_d = {csub_k(red_q[25:13]), csub_k(red_q[12:0])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      w_q    <= '0;
      prod_q <= '0;
      red_q  <= '0;
      res    <= '0;
    end else begin
      if (en[0]) begin
        a_q <= a;
        w_q <= w;
      end
      if (en[1]) prod_q <= prod_d;
      if (en[2]) red_q  <= red_d;
      if (en[3]) res    <= res_d;
    end
  end

endmodule

// File: rtl/mul_red_array.sv
// LANES-wide dual-mode modular multiplier with a 4-stage valid/ready pipeline.
module mul_red_array
  import mul_red_pkg::*;
#(
  parameter int LANES = 2,
  parameter int TAG_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [24*LANES-1:0]   in_a,
  input  logic [24*LANES-1:0]   in_w,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [24*LANES-1:0]   out_data,
  output logic                  out_mode,
  output logic [TAG_W-1:0]      out_tag,
  output logic [2:0]            in_flight
);

  logic [MR_LAT-1:0] vld;
  logic [MR_LAT-1:0] mode_q;
  logic [TAG_W-1:0]  tag_q [MR_LAT];
  logic [3:0]        en;
  logic              en_s1, en_s2, en_s3, en_s4;
  logic              accept, deliver;

  // A stage may load when it is empty or its occupant moves on, so bubbles collapse under stall.
  assign en_s4 = ~vld[3] | out_ready;
  assign en_s3 = ~vld[2] | en_s4;
  assign en_s2 = ~vld[1] | en_s3;
  assign en_s1 = ~vld[0] | en_s2;
  assign en    = {en_s4, en_s3, en_s2, en_s1};

  assign in_ready  = en_s1;
  assign accept    = in_valid & en_s1;
  assign deliver   = vld[3] & out_ready;
  assign out_valid = vld[3];
  assign out_mode  = mode_q[3];
  assign out_tag   = tag_q[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      mode_q    <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      tag_q[2]  <= '0;
      tag_q[3]  <= '0;
      in_flight <= '0;
    end else begin
      if (en_s1) begin
        vld[0]   <= in_valid;
        mode_q[0] <= in_mode;
        tag_q[0] <= in_tag;
      end
      if (en_s2) begin
        vld[1]   <= vld[0];
        mode_q[1] <= mode_q[0];
        tag_q[1] <= tag_q[0];
      end
      if (en_s3) begin
        vld[2]   <= vld[1];
        mode_q[2] <= mode_q[1];
        tag_q[2] <= tag_q[1];
      end
      if (en_s4) begin
        vld[3]   <= vld[2];
        mode_q[3] <= mode_q[2];
        tag_q[3] <= tag_q[2];
      end
      case ({accept, deliver})
        2'b10:   in_flight <= 3'(in_flight + 3'd1);
        2'b01:   in_flight <= 3'(in_flight - 3'd1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mul_red_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode_q[2:0]),
      .a    (in_a[24*g +: 24]),
      .w    (in_w[24*g +: 24]),
      .res  (out_data[24*g +: 24])
    );
  end

endmodule

// File: tb/tb_mul_red_array.sv
// Bench for mul_red_array: queue-based reference model plus directed literal vectors.
module tb_mul_red_array;
  localparam int LANES = 2;
  localparam int DW    = 24 * LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_mode;
  logic [DW-1:0] in_a, in_w;
  logic [7:0]    in_tag;
  logic          out_valid, out_ready, out_mode;
  logic [DW-1:0] out_data;
  logic [7:0]    out_tag;
  logic [2:0]    in_flight;

  int tests = 0;
  int fails = 0;
  bit rand_ready = 1'b0;

  always #5 clk = ~clk;

  mul_red_array #(.LANES(LANES), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_w(in_w), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .out_tag(out_tag), .in_flight(in_flight)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          m;
    logic [7:0]    t;
    int            acc;
  } beat_t;

  beat_t exp_q[$];

  function automatic logic [DW-1:0] ref_mul(input logic m, input logic [DW-1:0] a,
                                            input logic [DW-1:0] w);
    logic [DW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [23:0] la, lw;
      longint unsigned x, y;
      la = a[24*l +: 24];
      lw = w[24*l +: 24];
      if (m) begin
        x = 64'(la[22:0]);
        y = 64'(lw[22:0]);
        r[24*l +: 24] = 24'((x * y) % 64'd8380417);
      end else begin
        x = 64'(la[23:12]);
        y = 64'(lw[23:12]);
        r[24*l+12 +: 12] = 12'((x * y) % 64'd3329);
        x = 64'(la[11:0]);
        y = 64'(lw[11:0]);
        r[24*l +: 12] = 12'((x * y) % 64'd3329);
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  // Compare process: every non-reset cycle, checked mid-cycle on the falling edge.
  int            cyc = 0;
  int            last_stall = -1;
  bit            after_rst = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_mode;
  logic [7:0]    prev_tag;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      after_rst = 1'b1;
      prev_hold = 1'b0;
    end else begin
      if (after_rst) begin
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_out_mode",  64'(out_mode),  64'(0));
        chk("rst_out_tag",   64'(out_tag),   64'(0));
        chk("rst_in_flight", 64'(in_flight), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        after_rst = 1'b0;
      end
      chk("in_flight", 64'(in_flight), 64'(exp_q.size()));
      chk("in_ready", 64'(in_ready), 64'((exp_q.size() < 4) || out_ready));
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'(1));
        chk("hold_data",  64'(out_data),  64'(prev_data));
        chk("hold_mode",  64'(out_mode),  64'(prev_mode));
        chk("hold_tag",   64'(out_tag),   64'(prev_tag));
      end
      if (exp_q.size() > 0 && last_stall < exp_q[0].acc && cyc == exp_q[0].acc + 4)
        chk("latency_present", 64'(out_valid), 64'(1));
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          beat_t b;
          b = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(b.d));
          chk("out_mode", 64'(out_mode), 64'(b.m));
          chk("out_tag",  64'(out_tag),  64'(b.t));
          if (last_stall < b.acc) chk("latency", 64'(cyc - b.acc), 64'(4));
        end
      end
      if (out_valid && !out_ready) last_stall = cyc;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_mode = out_mode;
      prev_tag  = out_tag;
      if (in_valid && in_ready)
        exp_q.push_back('{d: ref_mul(in_mode, in_a, in_w), m: in_mode, t: in_tag, acc: cyc});
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic m, input logic [DW-1:0] a, input logic [DW-1:0] w,
                      input logic [7:0] t);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_a     = a;
    in_w     = w;
    in_tag   = t;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      tick();
      guard++;
      if (!done && guard > 200) begin
        chk("send_timeout", 64'(in_ready), 64'(1));
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [DW-1:0] d, input logic m, input logic [7:0] t);
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'(1));
    chk({nm, "_data"},  64'(out_data),  64'(d));
    chk({nm, "_mode"},  64'(out_mode),  64'(m));
    chk({nm, "_tag"},   64'(out_tag),   64'(t));
  endtask

  function automatic logic [DW-1:0] rnd48();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    if ($urandom_range(0, 7) == 0) v = '1;
    return v[DW-1:0];
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_mode = 1'b0;
    in_a = '0;
    in_w = '0;
    in_tag = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // Kyber: lane0 3328*3328 | 2*1665, lane1 non-canonical 4095*4095
    send(1'b0, {24'hFFF_FFF, 24'hD00_002}, {24'hFFF_FFF, 24'hD00_681}, 8'h11);
    repeat (3) tick();
    lit("kyber_lit", {24'h354_354, 24'h001_001}, 1'b0, 8'h11);
    idle(2);

    // Dilithium back-to-back, bit 23 set in lane1 must be ignored
    send(1'b1, {24'hFFFFFF, 24'd8380416}, {24'hFFFFFF, 24'd8380416}, 8'h21);
    send(1'b1, {24'd0, 24'd4194304}, {24'd5, 24'd2}, 8'h22);
    repeat (2) tick();
    lit("dil_lit1", {24'h007FFC, 24'h000001}, 1'b1, 8'h21);
    tick();
    lit("dil_lit2", {24'h000000, 24'h001FFF}, 1'b1, 8'h22);
    idle(3);

    for (int i = 0; i < 16; i++) send(1'(i % 2), rnd48(), rnd48(), 8'(i));
    idle(6);

    // Backpressure: out_ready low for 6 cycles while streaming
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'(i % 2), rnd48(), rnd48(), 8'(8'h40 + i));
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_a = rnd48();
    in_w = rnd48();
    in_tag = 8'h44;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'(0));
      chk("stall_in_flight", 64'(in_flight), 64'(4));
      chk("stall_out_valid", 64'(out_valid), 64'(1));
      tick();
    end
    out_ready = 1'b1;
    send(in_mode, in_a, in_w, in_tag);
    idle(8);
    chk("drain_in_flight", 64'(in_flight), 64'(0));

    // Reset with three beats in flight; none may ever appear
    for (int i = 0; i < 3; i++) send(1'b0, rnd48(), rnd48(), 8'(8'h50 + i));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(10);
    chk("post_rst_in_flight", 64'(in_flight), 64'(0));
    send(1'b1, {24'd3, 24'd7}, {24'd5, 24'd11}, 8'h60);
    repeat (3) tick();
    lit("post_rst_lit", {24'd15, 24'd77}, 1'b1, 8'h60);
    idle(3);

    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(1'($urandom_range(0, 1)), rnd48(), rnd48(), 8'(i));
    end
    rand_ready = 1'b0;
    out_ready = 1'b1;
    idle(8);
    chk("final_in_flight", 64'(in_flight), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
